// File: rtl/worley_noise_pipe_if.sv
// Pixel stream in, noise stream out. Valid-only: there is no ready, so the pipeline never stalls.
// The producer drives the in_* side (master) and the noise pipe drives the out_* side (slave).
interface worley_noise_pipe_if #(
    parameter int COORD_W = 10,
    parameter int NOISE_W = 8,
    parameter int IDX_W   = 2
);
    logic               in_valid;
    logic [COORD_W-1:0] in_x;
    logic [COORD_W-1:0] in_y;
    logic [2:0]         in_side;
    logic               out_valid;
    logic [NOISE_W-1:0] noise;
    logic [IDX_W-1:0]   nearest_idx;
    logic [2:0]         out_side;

    modport master (output in_valid, in_x, in_y, in_side,
                    input  out_valid, noise, nearest_idx, out_side);
    modport slave  (input  in_valid, in_x, in_y, in_side,
                    output out_valid, noise, nearest_idx, out_side);
endinterface

// File: rtl/worley_noise_pipe.sv
// Worley noise pipeline: nearest/second-nearest distance to NUM_POINTS bouncing points per pixel.
// Latency 4+clog2(NUM_POINTS) cycles, one pixel per cycle; no backpressure, bubbles flow through.
module worley_noise_pipe #(
    parameter int NUM_POINTS = 4,
    parameter int COORD_W    = 10,
    parameter int NOISE_W    = 8,
    parameter int H_RES      = 640,
    parameter int V_RES      = 480,
    parameter int DIST_SHIFT = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    worley_noise_pipe_if.slave            pix,
    input  logic [1:0]                    mode,
    input  logic                          frame_tick,
    input  logic                          cfg_we,
    input  logic [$clog2(NUM_POINTS)-1:0] cfg_idx,
    input  logic [COORD_W-1:0]            cfg_x,
    input  logic [COORD_W-1:0]            cfg_y,
    input  logic signed [3:0]             cfg_dx,
    input  logic signed [3:0]             cfg_dy
);
    localparam int IDX_W = $clog2(NUM_POINTS);
    localparam int LVL   = $clog2(NUM_POINTS);
    localparam int NP    = 1 << LVL;
    localparam int LAT   = 4 + LVL;
    localparam int SQ_W  = 2 * COORD_W;
    localparam int D_W   = 2 * COORD_W + 1;
    localparam int P_W   = COORD_W + 2;
    localparam int MAX_N = (1 << NOISE_W) - 1;

    // Feature point state
    logic [COORD_W-1:0] px_q  [NUM_POINTS], px_d  [NUM_POINTS];
    logic [COORD_W-1:0] py_q  [NUM_POINTS], py_d  [NUM_POINTS];
    logic signed [3:0]  pdx_q [NUM_POINTS], pdx_d [NUM_POINTS];
    logic signed [3:0]  pdy_q [NUM_POINTS], pdy_d [NUM_POINTS];

    // Datapath stages
    logic [COORD_W-1:0] ax_q  [NUM_POINTS], ax_d  [NUM_POINTS];
    logic [COORD_W-1:0] ay_q  [NUM_POINTS], ay_d  [NUM_POINTS];
    logic [SQ_W-1:0]    sqx_q [NUM_POINTS], sqx_d [NUM_POINTS];
    logic [SQ_W-1:0]    sqy_q [NUM_POINTS], sqy_d [NUM_POINTS];
    logic [D_W-1:0]     f1_q  [LVL+1][NP],  f1_d  [LVL+1][NP];
    logic [D_W-1:0]     f2_q  [LVL+1][NP],  f2_d  [LVL+1][NP];
    logic [IDX_W-1:0]   id_q  [LVL+1][NP],  id_d  [LVL+1][NP];

    // Control / sideband
    logic [LAT-2:0]     vld_sr_q, vld_sr_d;
    logic [2:0]         side_sr_q [LAT-1], side_sr_d [LAT-1];
    logic               out_valid_q, out_valid_d;
    logic [2:0]         out_side_q, out_side_d;
    logic [NOISE_W-1:0] noise_q, noise_d;
    logic [IDX_W-1:0]   nidx_q, nidx_d;

    // Returns {next position, next velocity}; an out-of-range step reflects the velocity and holds position.
    function automatic logic [COORD_W+3:0] move_axis(input logic [COORD_W-1:0] p,
                                                      input logic signed [3:0] d,
                                                      input int res);
        logic signed [P_W-1:0] nxt;
        nxt = $signed({2'b00, p}) + P_W'(d);
        if (int'(nxt) < 0 || int'(nxt) > res - 1)
            return {p, -d};
        return {nxt[COORD_W-1:0], d};
    endfunction

    function automatic logic [D_W-1:0] dmin(input logic [D_W-1:0] a, input logic [D_W-1:0] b);
        return (b < a) ? b : a;
    endfunction

    function automatic logic [NOISE_W-1:0] sat(input logic [D_W-1:0] v);
        logic [D_W-1:0] s;
        s = v >> DIST_SHIFT;
        if (s > D_W'(MAX_N))
            return '1;
        return s[NOISE_W-1:0];
    endfunction

    always_comb begin
        for (int i = 0; i < NUM_POINTS; i++) begin
            px_d[i]  = px_q[i];
            py_d[i]  = py_q[i];
            pdx_d[i] = pdx_q[i];
            pdy_d[i] = pdy_q[i];
            if (frame_tick) begin
                {px_d[i], pdx_d[i]} = move_axis(px_q[i], pdx_q[i], H_RES);
                {py_d[i], pdy_d[i]} = move_axis(py_q[i], pdy_q[i], V_RES);
            end
            // A config write overrides motion for its own point only
            if (cfg_we && int'(cfg_idx) == i) begin
                px_d[i]  = cfg_x;
                py_d[i]  = cfg_y;
                pdx_d[i] = cfg_dx;
                pdy_d[i] = cfg_dy;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_POINTS; i++) begin
            ax_d[i]  = (pix.in_x >= px_q[i]) ? pix.in_x - px_q[i] : px_q[i] - pix.in_x;
            ay_d[i]  = (pix.in_y >= py_q[i]) ? pix.in_y - py_q[i] : py_q[i] - pix.in_y;
            sqx_d[i] = SQ_W'(ax_q[i]) * SQ_W'(ax_q[i]);
            sqy_d[i] = SQ_W'(ay_q[i]) * SQ_W'(ay_q[i]);
        end
    end

    always_comb begin
        for (int l = 0; l <= LVL; l++) begin
            for (int j = 0; j < NP; j++) begin
                f1_d[l][j] = '0;
                f2_d[l][j] = '0;
                id_d[l][j] = '0;
            end
        end
        for (int j = 0; j < NUM_POINTS; j++) begin
            f1_d[0][j] = D_W'(sqx_q[j]) + D_W'(sqy_q[j]);
            f2_d[0][j] = '1;
            id_d[0][j] = IDX_W'(j);
        end
        // Padding leaves sit beyond any reachable distance so they never win
        for (int j = NUM_POINTS; j < NP; j++) begin
            f1_d[0][j] = '1;
            f2_d[0][j] = '1;
            id_d[0][j] = IDX_W'(j);
        end
        // Left child always holds the lower indices, so ties keep the left idx
        for (int l = 1; l <= LVL; l++) begin
            for (int j = 0; j < (NP >> l); j++) begin
                if (f1_q[l-1][2*j+1] < f1_q[l-1][2*j]) begin
                    f1_d[l][j] = f1_q[l-1][2*j+1];
                    id_d[l][j] = id_q[l-1][2*j+1];
                    f2_d[l][j] = dmin(f1_q[l-1][2*j], f2_q[l-1][2*j+1]);
                end else begin
                    f1_d[l][j] = f1_q[l-1][2*j];
                    id_d[l][j] = id_q[l-1][2*j];
                    f2_d[l][j] = dmin(f1_q[l-1][2*j+1], f2_q[l-1][2*j]);
                end
            end
        end
    end

    always_comb begin
        vld_sr_d     = {vld_sr_q[LAT-3:0], pix.in_valid};
        side_sr_d[0] = pix.in_side;
        for (int k = 1; k < LAT - 1; k++)
            side_sr_d[k] = side_sr_q[k-1];
        out_valid_d = vld_sr_q[LAT-2];
        out_side_d  = side_sr_q[LAT-2];
        noise_d     = noise_q;
        nidx_d      = nidx_q;
        if (vld_sr_q[LAT-2]) begin
            nidx_d = id_q[LVL][0];
            case (mode)
                2'd0:    noise_d = ~sat(f1_q[LVL][0]);
                2'd1:    noise_d = sat(f2_q[LVL][0] - f1_q[LVL][0]);
                default: noise_d = sat(f1_q[LVL][0]);
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_POINTS; i++) begin
                px_q[i]  <= COORD_W'(H_RES / (2 * NUM_POINTS) + i * H_RES / NUM_POINTS);
                py_q[i]  <= COORD_W'(V_RES / 2);
                pdx_q[i] <= (i % 2 == 0) ? 4'sd1 : -4'sd1;
                pdy_q[i] <= (i % 2 == 0) ? 4'sd1 : -4'sd1;
            end
            vld_sr_q <= '0;
            for (int k = 0; k < LAT - 1; k++)
                side_sr_q[k] <= '0;
            out_valid_q <= 1'b0;
            out_side_q  <= '0;
            noise_q     <= '0;
            nidx_q      <= '0;
        end else begin
            px_q        <= px_d;
            py_q        <= py_d;
            pdx_q       <= pdx_d;
            pdy_q       <= pdy_d;
            vld_sr_q    <= vld_sr_d;
            side_sr_q   <= side_sr_d;
            out_valid_q <= out_valid_d;
            out_side_q  <= out_side_d;
            noise_q     <= noise_d;
            nidx_q      <= nidx_d;
        end
    end

    // Pure datapath: validity is carried by vld_sr_q, so these need no reset
    always_ff @(posedge clk) begin
        ax_q  <= ax_d;
        ay_q  <= ay_d;
        sqx_q <= sqx_d;
        sqy_q <= sqy_d;
        f1_q  <= f1_d;
        f2_q  <= f2_d;
        id_q  <= id_d;
    end

    assign pix.out_valid   = out_valid_q;
    assign pix.out_side    = out_side_q;
    assign pix.noise       = noise_q;
    assign pix.nearest_idx = nidx_q;
endmodule

// File: tb/tb_worley_noise_pipe.sv
// Bench for worley_noise_pipe: directed pixels plus a random stream, checked by a queue-based scoreboard.
module tb_worley_noise_pipe;
    localparam int L = 6;
    localparam int N = 4;

    logic clk = 1'b0;
    logic reset;
    logic [1:0] mode;
    logic frame_tick, cfg_we;
    logic [1:0] cfg_idx;
    logic [9:0] cfg_x, cfg_y;
    logic signed [3:0] cfg_dx, cfg_dy;

    always #5 clk = ~clk;

    worley_noise_pipe_if #(.COORD_W(10), .NOISE_W(8), .IDX_W(2)) pif ();
    worley_noise_pipe_if #(.COORD_W(10), .NOISE_W(8), .IDX_W(2)) pif6 ();

    assign pif6.in_valid = pif.in_valid;
    assign pif6.in_x     = pif.in_x;
    assign pif6.in_y     = pif.in_y;
    assign pif6.in_side  = pif.in_side;

    worley_noise_pipe #(.NUM_POINTS(4), .COORD_W(10), .NOISE_W(8), .H_RES(640), .V_RES(480), .DIST_SHIFT(8)) dut (
        .clk(clk), .reset(reset), .pix(pif), .mode(mode), .frame_tick(frame_tick),
        .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_x(cfg_x), .cfg_y(cfg_y), .cfg_dx(cfg_dx), .cfg_dy(cfg_dy));

    worley_noise_pipe #(.NUM_POINTS(4), .COORD_W(10), .NOISE_W(8), .H_RES(640), .V_RES(480), .DIST_SHIFT(6)) dut6 (
        .clk(clk), .reset(reset), .pix(pif6), .mode(mode), .frame_tick(frame_tick),
        .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_x(cfg_x), .cfg_y(cfg_y), .cfg_dx(cfg_dx), .cfg_dy(cfg_dy));

    typedef struct {
        int cyc;
        int noise;
        int idx;
        bit chk6;
        int noise6;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc_cnt  = 0;
    bit   hist_v [8192];
    logic [2:0] hist_s [8192];
    int   hold_noise = 0;
    int   hold_idx   = 0;

    int mx[N], my[N], mdx[N], mdy[N];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, act, exp, cyc_cnt);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < N; i++) begin
            mx[i]  = 80 + 160 * i;
            my[i]  = 240;
            mdx[i] = (i % 2 == 0) ? 1 : -1;
            mdy[i] = (i % 2 == 0) ? 1 : -1;
        end
    endfunction

    function automatic void model_tick();
        for (int i = 0; i < N; i++) begin
            if (mx[i] + mdx[i] < 0 || mx[i] + mdx[i] > 639) mdx[i] = -mdx[i];
            else mx[i] = mx[i] + mdx[i];
            if (my[i] + mdy[i] < 0 || my[i] + mdy[i] > 479) mdy[i] = -mdy[i];
            else my[i] = my[i] + mdy[i];
        end
    endfunction

    function automatic void model_cfg(input int i, input int x, input int y, input int dx, input int dy);
        mx[i] = x; my[i] = y; mdx[i] = dx; mdy[i] = dy;
    endfunction

    function automatic int satv(input int v, input int sh);
        int s;
        s = v >>> sh;
        return (s > 255) ? 255 : s;
    endfunction

    function automatic int fmt(input int m, input int f1, input int f2, input int sh);
        if (m == 0) return 255 - satv(f1, sh);
        if (m == 1) return satv(f2 - f1, sh);
        return satv(f1, sh);
    endfunction

    // Straight sort over all points: nearest (lowest index on ties) and the best of the rest
    function automatic void model_eval(input int x, input int y, output int f1, output int f2, output int idx);
        int d[N];
        for (int i = 0; i < N; i++) d[i] = (x - mx[i]) * (x - mx[i]) + (y - my[i]) * (y - my[i]);
        idx = 0;
        for (int i = 1; i < N; i++) if (d[i] < d[idx]) idx = i;
        f1 = d[idx];
        f2 = 32'h7fffffff;
        for (int i = 0; i < N; i++) if (i != idx && d[i] < f2) f2 = d[i];
    endfunction

    task automatic cyc_begin();
        @(negedge clk);
        pif.in_valid = 1'b0;
        frame_tick   = 1'b0;
        cfg_we       = 1'b0;
    endtask

    task automatic send_dir(input int x, input int y, input logic [2:0] side, input int nz, input int idx,
                            input bit c6, input int nz6);
        exp_t e;
        cyc_begin();
        pif.in_valid = 1'b1;
        pif.in_x     = 10'(x);
        pif.in_y     = 10'(y);
        pif.in_side  = side;
        e.cyc = cyc_cnt; e.noise = nz; e.idx = idx; e.chk6 = c6; e.noise6 = nz6;
        q.push_back(e);
    endtask

    task automatic send_model(input int x, input int y, input logic [2:0] side);
        int f1, f2, idx;
        model_eval(x, y, f1, f2, idx);
        send_dir(x, y, side, fmt(int'(mode), f1, f2, 8), idx, 1'b1, fmt(int'(mode), f1, f2, 6));
    endtask

    task automatic send_bubble(input logic [2:0] side);
        cyc_begin();
        pif.in_side = side;
        pif.in_x    = 10'($urandom_range(639, 0));
        pif.in_y    = 10'($urandom_range(479, 0));
    endtask

    task automatic drain();
        repeat (L + 2) cyc_begin();
    endtask

    task automatic check_points();
        for (int i = 0; i < N; i++) begin
            send_model(mx[i] - 15, my[i], 3'(i));
            send_model(mx[i] + 15, my[i], 3'(i + 1));
            send_model(mx[i], my[i] + 15, 3'(i + 2));
        end
    endtask

    // Record what the DUT captures each edge; a reset edge kills everything that would emerge after it
    always @(posedge clk) begin
        hist_v[cyc_cnt] = pif.in_valid;
        hist_s[cyc_cnt] = pif.in_side;
        if (reset) begin
            for (int k = cyc_cnt - L + 1; k <= cyc_cnt; k++) begin
                if (k >= 0) begin
                    hist_v[k] = 1'b0;
                    hist_s[k] = 3'b000;
                end
            end
            while (q.size() > 0 && q[$].cyc >= cyc_cnt - L + 1) void'(q.pop_back());
            hold_noise = 0;
            hold_idx   = 0;
        end
        cyc_cnt++;
    end

    always @(negedge clk) begin
        if (cyc_cnt >= L) begin
            int src;
            exp_t e;
            src = cyc_cnt - L;
            check("out_valid", 32'(pif.out_valid), 32'(hist_v[src]));
            check("out_side", 32'(pif.out_side), 32'(hist_s[src]));
            if (pif.out_valid) begin
                if (q.size() == 0) begin
                    check("unexpected_out", 32'(q.size()), 32'd1);
                end else begin
                    e = q.pop_front();
                    check("latency_src_cycle", 32'(src), 32'(e.cyc));
                    check("noise", 32'(pif.noise), 32'(e.noise));
                    check("nearest_idx", 32'(pif.nearest_idx), 32'(e.idx));
                    if (e.chk6) check("noise_shift6", 32'(pif6.noise), 32'(e.noise6));
                    hold_noise = e.noise;
                    hold_idx   = e.idx;
                end
            end else begin
                check("hold_noise", 32'(pif.noise), 32'(hold_noise));
                check("hold_idx", 32'(pif.nearest_idx), 32'(hold_idx));
            end
        end
    end

    initial begin
        reset = 1'b1; mode = 2'd2; frame_tick = 1'b0; cfg_we = 1'b0;
        cfg_idx = '0; cfg_x = '0; cfg_y = '0; cfg_dx = '0; cfg_dy = '0;
        pif.in_valid = 1'b0; pif.in_x = '0; pif.in_y = '0; pif.in_side = '0;
        model_reset();
        repeat (3) @(negedge clk);
        check("rst_out_valid", 32'(pif.out_valid), 32'd0);
        check("rst_noise", 32'(pif.noise), 32'd0);
        check("rst_idx", 32'(pif.nearest_idx), 32'd0);
        check("rst_side", 32'(pif.out_side), 32'd0);
        reset = 1'b0;

        // Raw F1 on the default point layout
        send_dir(80, 240, 3'b001, 0, 0, 1'b0, 0);
        send_dir(160, 240, 3'b011, 25, 0, 1'b0, 0);
        send_dir(639, 0, 3'b101, 249, 3, 1'b0, 0);
        send_dir(0, 0, 3'b111, 250, 0, 1'b1, 255);
        drain();
        mode = 2'd0;
        send_dir(80, 240, 3'b010, 255, 0, 1'b0, 0);
        send_dir(639, 0, 3'b100, 6, 3, 1'b0, 0);
        drain();
        mode = 2'd1;
        send_dir(160, 240, 3'b110, 0, 0, 1'b0, 0);
        send_dir(80, 240, 3'b001, 100, 0, 1'b1, 255);
        send_dir(639, 0, 3'b000, 198, 3, 1'b0, 0);
        drain();
        mode = 2'd2;

        // Bounce at the right edge, and a config write coinciding with a tick
        cyc_begin();
        cfg_we = 1'b1; cfg_idx = 2'd0; cfg_x = 10'd639; cfg_y = 10'd240; cfg_dx = 4'sd1; cfg_dy = 4'sd0;
        model_cfg(0, 639, 240, 1, 0);
        cyc_begin();
        frame_tick = 1'b1;
        cfg_we = 1'b1; cfg_idx = 2'd1; cfg_x = 10'd100; cfg_y = 10'd100; cfg_dx = 4'sd2; cfg_dy = -4'sd3;
        model_tick();
        model_cfg(1, 100, 100, 2, -3);
        send_dir(624, 240, 3'b001, 0, 0, 1'b0, 0);
        send_dir(623, 240, 3'b010, 1, 0, 1'b0, 0);
        send_dir(100, 100, 3'b011, 0, 1, 1'b0, 0);
        cyc_begin();
        frame_tick = 1'b1;
        model_tick();
        send_dir(623, 240, 3'b100, 0, 0, 1'b0, 0);
        send_dir(622, 240, 3'b101, 1, 0, 1'b0, 0);
        send_dir(102, 97, 3'b110, 0, 1, 1'b0, 0);
        check_points();
        drain();

        // Random stream with gaps and sideband activity on bubbles
        mode = 2'd0;
        for (int n = 0; n < 100; n++) begin
            if ($urandom_range(9, 0) < 7)
                send_model(int'($urandom_range(639, 0)), int'($urandom_range(479, 0)), 3'($urandom_range(7, 0)));
            else
                send_bubble(3'($urandom_range(7, 0)));
        end
        drain();

        // Reset with four pixels in flight
        mode = 2'd2;
        for (int n = 0; n < 4; n++) send_model(200 + n, 100 + n, 3'b111);
        cyc_begin();
        reset = 1'b1;
        model_reset();
        cyc_begin();
        reset = 1'b0;
        repeat (L) cyc_begin();
        check_points();
        cyc_begin();
        frame_tick = 1'b1;
        model_tick();
        check_points();
        drain();

        check("scoreboard_empty", 32'(q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/worley_noise_pipe.md
Name: worley_noise_pipe

Overview:
- Pipelined, parametrised Worley (cellular) noise generator for the VGA pixel path.
- Takes a pixel coordinate stream plus sync/blank sideband and returns an NOISE_W-bit noise value with the sideband, at a fixed latency.
- Supports NUM_POINTS moving feature points that bounce off the screen edges.
- Points are updated once per frame and are reloadable through a config port.
- Three output modes: inverted F1, F2-F1 (cell edges), and raw F1.

Parameters:
- NUM_POINTS, 4, number of feature points; must be >= 2.
- COORD_W, 10, coordinate width.
- NOISE_W, 8, output noise width.
- H_RES, 640, horizontal bound for point motion.
- V_RES, 480, vertical bound for point motion.
- DIST_SHIFT, 8, right shift applied to the squared distance before saturation.

Ports:
- clk  in  1  pixel clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  pixel valid
- in_x  in  COORD_W  pixel X
- in_y  in  COORD_W  pixel Y
- in_side  in  3  sideband {hs, vs, de}, delayed with the data
- mode  in  2  0=~F1, 1=F2-F1, 2=F1, 3=reserved (behaves as 2)
- frame_tick  in  1  one-cycle pulse; advances point motion
- cfg_we  in  1  write one point's state
- cfg_idx  in  clog2(NUM_POINTS)  point index
- cfg_x  in  COORD_W  new X position
- cfg_y  in  COORD_W  new Y position
- cfg_dx  in  4  signed X velocity
- cfg_dy  in  4  signed Y velocity
- out_valid  out  1  result valid
- noise  out  NOISE_W  noise value
- nearest_idx  out  clog2(NUM_POINTS)  index of the nearest point
- out_side  out  3  delayed sideband

Behaviour:
- Clock and reset: one clock `clk`; `reset` is synchronous and active-high.
- Reset:
  - out_valid=0, noise=0, nearest_idx=0, out_side=0.
  - All pipeline valid bits are cleared; in-flight pixels are dropped and never emerge.
  - Point i resets to x=H_RES/(2*NUM_POINTS)+i*H_RES/NUM_POINTS, y=V_RES/2.
  - Point i resets to dx=+1 if i is even, else -1; dy=+1 if i is even, else -1.
- Latency: L = 4 + clog2(NUM_POINTS) cycles, fixed, fully pipelined, one pixel per cycle. L = 6 for the default NUM_POINTS.
- Pipeline stages:
  - S1: absolute deltas |x-px_i|, |y-py_i| per point.
  - S2: squares.
  - S3: sum; the squared distance d_i is 2*COORD_W+1 bits wide and never truncated.
  - S4..S(3+clog2 N): registered reduction tree. Each node carries (F1, F2, idx).
    - Merge of A and B: F1=min(A.F1, B.F1).
    - F2 = the smallest of the remaining three values.
    - On a tie, the lower index wins for idx.
  - Last stage: output formatting.
- Sideband and in_valid are delayed exactly L cycles. in_valid=0 entries still propagate as bubbles; out_valid mirrors the delayed in_valid.
- Output formatting: sat(v) = min(v>>DIST_SHIFT, 2^NOISE_W-1).
  - mode 0: noise = ~sat(F1).
  - mode 1: noise = sat(F2-F1).
  - mode 2/3: noise = sat(F1).
  - mode is sampled at the final stage, not with the pixel.
- When out_valid=0, noise and nearest_idx hold their last values.
- Point motion on frame_tick, per point and per axis independently:
  - If p+d < 0 or p+d > RES-1, negate d and hold p this tick.
  - Otherwise p <= p+d.
- Points are read by S1 combinationally from the point registers. Pixels entering after the tick see the new positions; frame_tick is expected during blanking.
- cfg_we writes point cfg_idx's position and velocity in one cycle. When cfg_we and frame_tick coincide, cfg_we wins for that index and other points move normally.
- cfg_idx >= NUM_POINTS is ignored.
- reset has priority over cfg_we and frame_tick.

Test Plan:
- Reset with default parameters, then in_x=80, in_y=240, in_valid=1, mode=2 → after exactly 6 cycles: out_valid=1, noise=0, nearest_idx=0. With mode=0 → noise=0xFF.
- Pixel (160,240), which is equidistant from p0 and p1 (d=6400) → mode 2: noise=25, nearest_idx=0 (tie goes to lower index). Mode 1: noise=0.
- Pixel (639,0), nearest point p3 at (560,240), d=63841 → mode 2: noise=249, nearest_idx=3. Same pixel (0,0) with DIST_SHIFT=6, d=64000 → noise=255 (saturated).
- Bounce: cfg_we with idx=0, x=639, dx=+1, dy=0 → first frame_tick: x stays 639, dx=-1. Second tick: x=638. Also assert frame_tick and cfg_we together for idx=1 → point 1 takes the cfg values, point 0 moves.
- Stream 100 pixels with random in_valid gaps and sideband patterns → out_side and out_valid equal the inputs delayed by exactly 6 cycles; results match the reference model for every valid pixel.
- Assert reset while 4 valid pixels are in flight → out_valid stays 0 for the next 6 cycles, and all points return to their reset positions and velocities.
